load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store unit with lane placement, load extension and ack timeout; optional macro LSU_MISALIGN_EXC_EN faults misaligned accesses
module load_store_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  // Request decode: byte count, force-aligned lane, enables, replicated store data
  logic [3:0]          req_nbytes;
  logic [LW-1:0]       req_lane;
  logic [NB-1:0]       req_be_base;
  logic [NB-1:0]       req_be;
  logic [DATA_W-1:0]   req_wrep;
  logic                req_dword_bad;
  logic                req_misalign;

  assign req_nbytes    = 4'd1 << req_size;
  // Clearing the low lane bits to the access size gives the force-aligned lane
  assign req_lane      = req_addr[LW-1:0] & ~LW'(req_nbytes - 4'd1);
  assign req_be        = req_be_base << req_lane;
  assign req_dword_bad = (DATA_W == 32) && (req_size == 2'b11);

`ifdef LSU_MISALIGN_EXC_EN
  assign req_misalign  = |(req_addr[2:0] & 3'(req_nbytes - 4'd1));
`else
  assign req_misalign  = 1'b0;
`endif

  // Build the unshifted enable mask and replicate sized store data into every lane group
  always_comb begin
    req_be_base = '0;
    req_wrep    = '0;
    for (int i = 0; i < NB; i++) begin
      req_be_base[i] = (4'(i) < req_nbytes);
      case (req_size)
        2'b00:   req_wrep[8*i +: 8] = req_wdata[7:0];
        2'b01:   req_wrep[8*i +: 8] = req_wdata[8*(i%2) +: 8];
        2'b10:   req_wrep[8*i +: 8] = req_wdata[8*(i%4) +: 8];
        default: req_wrep[8*i +: 8] = req_wdata[8*i +: 8];
      endcase
    end
  end

  // Load path: shift the addressed lanes down, then zero/sign fill above the field
  logic [3:0]          ld_nbytes;
  logic [DATA_W-1:0]   ld_shift;
  logic                ld_sign;
  logic [DATA_W-1:0]   ld_data;

  assign ld_nbytes = 4'd1 << size_q;
  assign ld_shift  = mem_rdata >> {lane_q, 3'b000};

  // Pick the field's top bit and extend it over the unused upper bytes
  always_comb begin
    ld_data = '0;
    case (size_q)
      2'b00:   ld_sign = ld_shift[7];
      2'b01:   ld_sign = ld_shift[15];
      2'b10:   ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[DATA_W-1];
    endcase
    for (int i = 0; i < NB; i++) begin
      ld_data[8*i +: 8] = (4'(i) < ld_nbytes) ? ld_shift[8*i +: 8] : {8{signed_q & ld_sign}};
    end
  end

  // Next-state and datapath update for the IDLE/ACCESS/RESP sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_lane;
          addr_d   = req_addr & ~ADDR_W'(NB - 1);
          be_d     = req_be;
          wdata_d  = req_wrep;
          rdata_d  = '0;
          err_d    = 1'b0;
          // Illegal size or faulted misalignment answers without touching memory
          if (req_dword_bad || req_misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : ld_data;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      lane_q   <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule
